// File: rtl/keynsham_spi_xfer_engine.sv
// Transfer engine for the keynsham SPI master: 8 KiB dual-port buffer plus mode-0 shifter.
// Build option SPI_ENGINE_LSB_FIRST_EN adds the lsb_first port for LSB-first framing.
module keynsham_spi_xfer_engine #(
  parameter int unsigned BUF_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] buf_addr,
  input  logic [7:0]  buf_wr_val,
  input  logic        buf_wr_en,
  output logic [7:0]  buf_rd_val,
  input  logic [8:0]  divider,
  input  logic        xfer_start,
  input  logic [12:0] xfer_length,
  output logic        xfer_complete,
  output logic        busy,
  input  logic        miso,
  output logic        mosi,
  output logic        sclk
`ifdef SPI_ENGINE_LSB_FIRST_EN
  ,
  input  logic        lsb_first
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, SHIFT, STORE, DONE} state_e;

  state_e      state_q, state_d;
  logic [12:0] len_q, len_d;
  logic [12:0] addr_q, addr_d;
  logic [12:0] addr_nxt;
  logic [8:0]  div_q, div_d;
  logic [8:0]  div_cnt_q, div_cnt_d;
  logic [2:0]  fall_cnt_q, fall_cnt_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        cmpl_q, cmpl_d;
  logic [7:0]  buf_rd_val_q;
  logic [7:0]  rd_b_q;
  logic        eng_we;
  logic        lsb_sel;

  logic [7:0]  mem [BUF_BYTES];

`ifdef SPI_ENGINE_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_sel = lsb_q;
`else
  assign lsb_sel = 1'b0;
`endif

  assign addr_nxt = addr_q + 13'd1;

  // Engine write is issued last so it overrides a same-address bus write.
  always_ff @(posedge clk) begin
    if (buf_wr_en) mem[buf_addr] <= buf_wr_val;
    if (eng_we)    mem[addr_q]   <= rx_sr_q;
    rd_b_q <= mem[addr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_rd_val_q <= '0;
    else     buf_rd_val_q <= mem[buf_addr];
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    fall_cnt_d = fall_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cmpl_d     = 1'b0;
    eng_we     = 1'b0;
`ifdef SPI_ENGINE_LSB_FIRST_EN
    lsb_d      = lsb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (xfer_start) begin
          len_d  = xfer_length;
          addr_d = '0;
          div_d  = divider;
`ifdef SPI_ENGINE_LSB_FIRST_EN
          lsb_d  = lsb_first;
`endif
          state_d = (xfer_length == 13'd0) ? DONE : LOAD;
        end
      end
      LOAD: state_d = FETCH;
      FETCH: begin
        tx_sr_d    = rd_b_q;
        mosi_d     = lsb_sel ? rd_b_q[0] : rd_b_q[7];
        div_cnt_d  = '0;
        fall_cnt_d = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            rx_sr_d = lsb_sel ? {miso, rx_sr_q[7:1]} : {rx_sr_q[6:0], miso};
          end else begin
            tx_sr_d    = lsb_sel ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
            mosi_d     = lsb_sel ? tx_sr_q[1] : tx_sr_q[6];
            fall_cnt_d = fall_cnt_q + 3'd1;
            if (fall_cnt_q == 3'd7) state_d = STORE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 9'd1;
        end
      end
      STORE: begin
        eng_we = 1'b1;
        if (addr_nxt == len_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_nxt;
          state_d = LOAD;
        end
      end
      DONE: begin
        cmpl_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      fall_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      cmpl_q     <= 1'b0;
`ifdef SPI_ENGINE_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      cmpl_q     <= cmpl_d;
`ifdef SPI_ENGINE_LSB_FIRST_EN
      lsb_q      <= lsb_d;
`endif
    end
  end

  assign buf_rd_val    = buf_rd_val_q;
  assign xfer_complete = cmpl_q;
  assign busy          = busy_q;
  assign mosi          = mosi_q;
  assign sclk          = sclk_q;

endmodule

// File: tb/tb_keynsham_spi_xfer_engine.sv
// Self-checking bench for keynsham_spi_xfer_engine: transfer-level model plus per-cycle monitor.
module tb_keynsham_spi_xfer_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] buf_addr = '0;
  logic [7:0]  buf_wr_val = '0;
  logic        buf_wr_en = 1'b0;
  logic [7:0]  buf_rd_val;
  logic [8:0]  divider = '0;
  logic        xfer_start = 1'b0;
  logic [12:0] xfer_length = '0;
  logic        xfer_complete, busy, miso, mosi, sclk;
`ifdef SPI_ENGINE_LSB_FIRST_EN
  logic        lsb_first = 1'b0;
`endif

  keynsham_spi_xfer_engine #(.BUF_BYTES(8192)) dut (
    .clk(clk), .rst(rst), .buf_addr(buf_addr), .buf_wr_val(buf_wr_val),
    .buf_wr_en(buf_wr_en), .buf_rd_val(buf_rd_val), .divider(divider),
    .xfer_start(xfer_start), .xfer_length(xfer_length),
    .xfer_complete(xfer_complete), .busy(busy), .miso(miso), .mosi(mosi), .sclk(sclk)
`ifdef SPI_ENGINE_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transfer-level model state, written only by the stimulus process.
  logic [7:0] model_mem [0:8191];
  logic       exp_bits [0:255];
  logic [7:0] exp_rx [0:31];
  int         exp_nbits = 0;
  int         cur_len = 0;
  int         cur_div = 0;
  int         xfer_id = 0;
  int         start_cyc = 0;
  int         b_lo = -100, b_hi = -100, c_at = -100;
  logic       tie_inv = 1'b1;
  logic [7:0] miso_pat = '0;
  logic       cur_lsb = 1'b0;

  // Monitor state, written only by the compare process.
  int         mon_id = 0;
  int         rises = 0;
  int         rib = 0;
  int         last_tog = 0;
  int         busy_cnt = 0;
  int         cmpl_seen = -1;
  logic       prev_sclk = 1'b0;
  logic [7:0] obs_tx = '0;

  logic [2:0] pat_idx;
  assign pat_idx = cur_lsb ? 3'(rib) : 3'(7 - rib);
  assign miso    = tie_inv ? ~mosi : miso_pat[pat_idx];

  always @(negedge clk) begin
    if (rst) begin
      prev_sclk = sclk;
    end else begin
      if (mon_id != xfer_id) begin
        mon_id    = xfer_id;
        rises     = 0;
        rib       = 0;
        last_tog  = start_cyc;
        busy_cnt  = 0;
        cmpl_seen = -1;
        obs_tx    = '0;
      end
      chk("busy", 32'(busy), 32'(cyc >= b_lo && cyc < b_hi));
      chk("xfer_complete", 32'(xfer_complete), 32'(cyc == c_at));
      if (xfer_complete) cmpl_seen = cyc;
      if (busy) busy_cnt++;
      if (!(cyc >= b_lo && cyc < b_hi)) begin
        chk("idle_sclk", 32'(sclk), 32'd0);
        chk("idle_mosi", 32'(mosi), 32'd0);
      end
      if (sclk !== prev_sclk) begin
        if (sclk && rib == 0) chk("sclk_gap", cyc - last_tog, cur_div + 4);
        else                  chk("sclk_half", cyc - last_tog, cur_div + 1);
        if (sclk) begin
          if (rises < exp_nbits && rises < 256) chk("mosi_bit", 32'(mosi), 32'(exp_bits[rises]));
          else chk("extra_sclk_rise", 32'(rises), 32'(exp_nbits));
          obs_tx = {obs_tx[6:0], mosi};
          rises++;
          rib = (rib == 7) ? 0 : rib + 1;
        end
        last_tog = cyc;
      end
      prev_sclk = sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] v);
    buf_addr = a; buf_wr_val = v; buf_wr_en = 1'b1;
    tick(1);
    buf_wr_en = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic rd(input logic [12:0] a, output logic [7:0] v);
    buf_addr = a;
    tick(1);
    v = buf_rd_val;
  endtask

  task automatic start_xfer(input int len, input int d, input logic inv,
                            input logic [7:0] pat, input logic lsb);
    cur_len = len; cur_div = d; tie_inv = inv; miso_pat = pat; cur_lsb = lsb;
    exp_nbits = len * 8;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++)
        exp_bits[i*8+b] = lsb ? model_mem[i][b] : model_mem[i][7-b];
      exp_rx[i] = inv ? ~model_mem[i] : pat;
    end
    start_cyc = cyc;
    b_lo = cyc + 1;
    c_at = cyc + 2 + len * (16 * (d + 1) + 3);
    b_hi = c_at;
    xfer_length = 13'(len);
    divider = 9'(d);
`ifdef SPI_ENGINE_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    xfer_start = 1'b1;
    xfer_id++;
    tick(1);
    xfer_start = 1'b0;
  endtask

  task automatic finish_xfer();
    logic [7:0] v;
    tick(c_at + 1 - cyc);
    for (int i = 0; i < cur_len; i++) model_mem[i] = exp_rx[i];
    for (int i = 0; i < cur_len; i++) begin
      rd(13'(i), v);
      chk("buf_after_xfer", 32'(v), 32'(model_mem[i]));
    end
  endtask

  logic [7:0] rv;

  initial begin
    tick(3);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmpl", 32'(xfer_complete), 32'd0);
    chk("rst_rd_val", 32'(buf_rd_val), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: single byte, divider 0, miso = ~mosi, bus write collides with engine STORE
    wr(13'd0, 8'hA5);
    start_xfer(1, 0, 1'b1, 8'h00, 1'b0);
    tick(18);
    buf_addr = 13'd0; buf_wr_val = 8'hEE; buf_wr_en = 1'b1;
    tick(1);
    buf_wr_en = 1'b0;
    finish_xfer();
    chk("t1_mosi_seq", 32'(obs_tx), 32'h0000_00A5);
    chk("t1_rises", rises, 8);
    chk("t1_cmpl_latency", cmpl_seen - start_cyc, 21);
    chk("t1_busy_cycles", busy_cnt, 20);
    rd(13'd0, rv);
    chk("t1_buf0", 32'(rv), 32'h0000_005A);

    // 2: two bytes, divider 3, fixed miso pattern
    wr(13'd0, 8'h12);
    wr(13'd1, 8'h34);
    start_xfer(2, 3, 1'b0, 8'h96, 1'b0);
    finish_xfer();
    chk("t2_rises", rises, 16);
    chk("t2_cmpl_latency", cmpl_seen - start_cyc, 136);
    rd(13'd1, rv);
    chk("t2_buf1", 32'(rv), 32'h0000_0096);

    // 3: zero length
    start_xfer(0, 5, 1'b1, 8'h00, 1'b0);
    finish_xfer();
    chk("t3_cmpl_latency", cmpl_seen - start_cyc, 2);
    chk("t3_busy_cycles", busy_cnt, 1);
    chk("t3_rises", rises, 0);

    // 4: restart attempt mid-transfer is ignored; divider/length stay latched
    wr(13'd0, 8'h01);
    wr(13'd1, 8'h80);
    wr(13'd2, 8'hFF);
    wr(13'd3, 8'h5C);
    start_xfer(3, 1, 1'b1, 8'h00, 1'b0);
    tick(9);
    xfer_length = 13'd5; divider = 9'd0; xfer_start = 1'b1;
    tick(1);
    xfer_start = 1'b0;
    finish_xfer();
    chk("t4_rises", rises, 24);
    chk("t4_cmpl_latency", cmpl_seen - start_cyc, 107);
    rd(13'd2, rv);
    chk("t4_buf2", 32'(rv), 32'h0000_0000);
    rd(13'd3, rv);
    chk("t4_buf3_untouched", 32'(rv), 32'(model_mem[3]));

    // 5: reset during the second byte of a four-byte transfer
    wr(13'd0, 8'h3C);
    wr(13'd1, 8'hC3);
    wr(13'd2, 8'h11);
    wr(13'd3, 8'h22);
    start_xfer(4, 0, 1'b1, 8'h00, 1'b0);
    tick(28);
    rst = 1'b1;
    b_hi = cyc;
    c_at = -100;
    #1;
    chk("t5_rst_sclk", 32'(sclk), 32'd0);
    chk("t5_rst_mosi", 32'(mosi), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("t5_no_complete", cmpl_seen, -1);
    model_mem[0] = 8'hC3;
    rd(13'd0, rv);
    chk("t5_buf0", 32'(rv), 32'h0000_00C3);
    rd(13'd1, rv);
    chk("t5_buf1", 32'(rv), 32'h0000_00C3);
    rd(13'd2, rv);
    chk("t5_buf2", 32'(rv), 32'h0000_0011);
    rd(13'd3, rv);
    chk("t5_buf3", 32'(rv), 32'h0000_0022);

`ifdef SPI_ENGINE_LSB_FIRST_EN
    // 6: LSB-first framing
    wr(13'd0, 8'h01);
    start_xfer(1, 0, 1'b0, 8'h80, 1'b1);
    finish_xfer();
    chk("t6_mosi_seq", 32'(obs_tx), 32'h0000_0080);
    rd(13'd0, rv);
    chk("t6_buf0", 32'(rv), 32'h0000_0080);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
